// File: rtl/uart_axil_stream_master.sv
// uart_axil_stream_master
// AXI-lite master that turns a memory-mapped UART slave into a TX byte
// stream (single-beat writes to the data register) and an RX byte stream
// (periodic count polls followed by data-register reads).
//
// Handshake semantics (all channels, both streams and AXI-lite): a beat
// transfers on a rising clk edge where valid and ready are both high. A
// valid, once raised, stays high with its payload held stable until that
// transfer; ready may depend on valid.
module uart_axil_stream_master #(
  parameter int unsigned           ADDR_WIDTH     = 4,
  parameter logic [ADDR_WIDTH-1:0] DATA_ADDR      = ADDR_WIDTH'(4'h0),
  parameter logic [ADDR_WIDTH-1:0] RX_NUM_ADDR    = ADDR_WIDTH'(4'h4),
  parameter int unsigned           POLL_CYCLES    = 64,
  parameter bit                    BYTE_LANE_HIGH = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  // TX byte stream
  input  logic                  tx_valid_i,
  input  logic [7:0]            tx_data_i,
  output logic                  tx_ready_o,
  // RX byte stream
  output logic                  rx_valid_o,
  output logic [7:0]            rx_data_o,
  input  logic                  rx_ready_i,
  // AXI-lite write address
  output logic                  awvalid_o,
  output logic [ADDR_WIDTH-1:0] awaddr_o,
  output logic [2:0]            awprot_o,
  input  logic                  awready_i,
  // AXI-lite write data
  output logic                  wvalid_o,
  output logic [31:0]           wdata_o,
  output logic [3:0]            wstrb_o,
  input  logic                  wready_i,
  // AXI-lite write response
  input  logic                  bvalid_i,
  input  logic [1:0]            bresp_i,
  output logic                  bready_o,
  // AXI-lite read address
  output logic                  arvalid_o,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic [2:0]            arprot_o,
  input  logic                  arready_i,
  // AXI-lite read data
  input  logic                  rvalid_i,
  input  logic [31:0]           rdata_i,
  input  logic [1:0]            rresp_i,
  output logic                  rready_o,
  // Status / debug
  output logic                  resp_err_o,
  output logic [2:0]            state_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_REQ   = 3'd1;
  localparam logic [2:0] S_WR_RESP  = 3'd2;
  localparam logic [2:0] S_NUM_REQ  = 3'd3;
  localparam logic [2:0] S_NUM_RESP = 3'd4;
  localparam logic [2:0] S_DAT_REQ  = 3'd5;
  localparam logic [2:0] S_DAT_RESP = 3'd6;
  localparam logic [2:0] S_RX_HOLD  = 3'd7;

  localparam logic TURN_TX = 1'b0;
  localparam logic TURN_RX = 1'b1;

  localparam int unsigned   TW          = $clog2(POLL_CYCLES);
  localparam logic [TW-1:0] POLL_MAX    = TW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] POLL_MAX_M1 = TW'(POLL_CYCLES - 2);

  logic [2:0]    state;
  logic          turn;
  logic [TW-1:0] timer;
  logic          poll_due;
  logic [7:0]    rx_pending;

  logic       tx_pend;
  logic       rx_pend;
  logic       pick_tx;
  logic       pick_rx;
  logic       start_poll;
  logic       aw_done;
  logic       w_done;
  logic [7:0] rd_byte;
  logic       unused_rdata;

  // Byte lane carrying the count / received byte in read data.
  assign rd_byte      = BYTE_LANE_HIGH ? rdata_i[31:24] : rdata_i[7:0];
  assign unused_rdata = ^rdata_i[23:8];

  // Service requests and the IDLE arbitration between them.
  assign tx_pend    = tx_valid_i;
  assign rx_pend    = (rx_pending != 8'd0) || poll_due;
  assign pick_tx    = tx_pend && (!rx_pend || (turn == TURN_TX));
  assign pick_rx    = rx_pend && (!tx_pend || (turn == TURN_RX));
  assign start_poll = (state == S_IDLE) && pick_rx && (rx_pending == 8'd0);

  // A write channel counts as done once its beat has transferred.
  assign aw_done = !awvalid_o || awready_i;
  assign w_done  = !wvalid_o || wready_i;

  assign tx_ready_o = (state == S_IDLE) && pick_tx;
  assign bready_o   = (state == S_WR_RESP);
  assign rready_o   = (state == S_NUM_RESP) || (state == S_DAT_RESP);
  assign rx_valid_o = (state == S_RX_HOLD);
  assign awprot_o   = 3'b000;
  assign arprot_o   = 3'b000;
  assign state_o    = state;

  // Main sequencer: one AXI transaction at a time, registered request outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      turn      <= TURN_TX;
      awvalid_o <= 1'b0;
      awaddr_o  <= '0;
      wvalid_o  <= 1'b0;
      wdata_o   <= '0;
      wstrb_o   <= '0;
      arvalid_o <= 1'b0;
      araddr_o  <= '0;
      rx_data_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_tx) begin
            state     <= S_WR_REQ;
            turn      <= ~turn;
            awvalid_o <= 1'b1;
            awaddr_o  <= DATA_ADDR;
            wvalid_o  <= 1'b1;
            wdata_o   <= {4{tx_data_i}};
            wstrb_o   <= 4'hF;
          end else if (pick_rx) begin
            turn      <= ~turn;
            arvalid_o <= 1'b1;
            // Draining already-counted bytes wins over a fresh poll.
            if (rx_pending != 8'd0) begin
              state    <= S_DAT_REQ;
              araddr_o <= DATA_ADDR;
            end else begin
              state    <= S_NUM_REQ;
              araddr_o <= RX_NUM_ADDR;
            end
          end
        end
        S_WR_REQ: begin
          if (awvalid_o && awready_i) awvalid_o <= 1'b0;
          if (wvalid_o && wready_i)   wvalid_o  <= 1'b0;
          if (aw_done && w_done)      state     <= S_WR_RESP;
        end
        S_WR_RESP: begin
          if (bvalid_i) state <= S_IDLE;
        end
        S_NUM_REQ: begin
          if (arready_i) begin
            arvalid_o <= 1'b0;
            state     <= S_NUM_RESP;
          end
        end
        S_NUM_RESP: begin
          if (rvalid_i) state <= S_IDLE;
        end
        S_DAT_REQ: begin
          if (arready_i) begin
            arvalid_o <= 1'b0;
            state     <= S_DAT_RESP;
          end
        end
        S_DAT_RESP: begin
          // Data is delivered even when the response reports an error.
          if (rvalid_i) begin
            rx_data_o <= rd_byte;
            state     <= S_RX_HOLD;
          end
        end
        S_RX_HOLD: begin
          if (rx_ready_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Poll timer: counts IDLE cycles, flags a due poll, restarts when a poll begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer    <= '0;
      poll_due <= 1'b0;
    end else if (start_poll) begin
      timer    <= '0;
      poll_due <= 1'b0;
    end else if ((state == S_IDLE) && (timer != POLL_MAX)) begin
      timer <= timer + TW'(1);
      if (timer == POLL_MAX_M1) poll_due <= 1'b1;
    end
  end

  // Bytes still to drain: loaded by a count read, reduced by each RX transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_pending <= 8'd0;
    end else if ((state == S_NUM_RESP) && rvalid_i) begin
      // An errored count cannot be trusted, so nothing is drained on it.
      rx_pending <= (rresp_i != 2'b00) ? 8'd0 : rd_byte;
    end else if ((state == S_RX_HOLD) && rx_ready_i) begin
      rx_pending <= rx_pending - 8'd1;
    end
  end

  // Sticky error flag for any non-OKAY write or read response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_err_o <= 1'b0;
    end else if (((state == S_WR_RESP) && bvalid_i && (bresp_i != 2'b00)) ||
                 (((state == S_NUM_RESP) || (state == S_DAT_RESP)) &&
                  rvalid_i && (rresp_i != 2'b00))) begin
      resp_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_axil_stream_master.sv
// Bench for uart_axil_stream_master: an AXI-lite UART slave model with a
// receive FIFO, stream scoreboards, directed scenarios and a random phase.
module tb_uart_axil_stream_master;

  localparam int         POLL   = 16;
  localparam logic [3:0] DATA_A = 4'h0;
  localparam logic [3:0] NUM_A  = 4'h4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        tx_valid_i, tx_ready_o, rx_valid_o, rx_ready_i;
  logic [7:0]  tx_data_i, rx_data_o;
  logic        awvalid_o, awready_i, wvalid_o, wready_i, bvalid_i, bready_o;
  logic        arvalid_o, arready_i, rvalid_i, rready_o, resp_err_o;
  logic [3:0]  awaddr_o, araddr_o, wstrb_o;
  logic [2:0]  awprot_o, arprot_o, state_o;
  logic [31:0] wdata_o, rdata_i;
  logic [1:0]  bresp_i, rresp_i;

  uart_axil_stream_master #(.POLL_CYCLES(POLL)) dut (
    .clk(clk), .rst(rst),
    .tx_valid_i(tx_valid_i), .tx_data_i(tx_data_i), .tx_ready_o(tx_ready_o),
    .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o), .rx_ready_i(rx_ready_i),
    .awvalid_o(awvalid_o), .awaddr_o(awaddr_o), .awprot_o(awprot_o), .awready_i(awready_i),
    .wvalid_o(wvalid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wready_i(wready_i),
    .bvalid_i(bvalid_i), .bresp_i(bresp_i), .bready_o(bready_o),
    .arvalid_o(arvalid_o), .araddr_o(araddr_o), .arprot_o(arprot_o), .arready_i(arready_i),
    .rvalid_i(rvalid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rready_o(rready_o),
    .resp_err_o(resp_err_o), .state_o(state_o)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] tx_exp_q[$];   // bytes accepted on TX, awaiting their AXI write
  logic [7:0] rx_exp_q[$];   // bytes loaded into the UART, awaiting RX delivery
  logic [7:0] uart_fifo[$];  // slave model receive FIFO

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model config and statistics ----------------
  int aw_dly = 0, w_dly = 0, ar_dly = 0, rsp_dly = 0;
  bit rand_dly = 0, dat_err_rand = 0, cnt_err_once = 0, dat_err_once = 0;
  logic [1:0] bresp_next = 2'b00;
  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  bit aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_got, w_got, ar_got, ar_prev;
  logic [3:0] aw_a, ar_a, w_s;
  logic [31:0] w_d;
  int n_b = 0, n_writes = 0, n_data_reads = 0, n_polls_nz = 0, n_poll_req = 0;
  int n_ar_req = 0, n_rx = 0, rx_extra = 0, wr_extra = 0, fifo_under = 0;
  int aw_hi = 0, w_hi = 0, aw_run = 0, w_run = 0;
  int cyc = 0, last_poll_cyc = -1, poll_gap = 0;

  // Slave model and stream monitors, all sampled on the falling edge.
  always @(negedge clk) begin
    logic [31:0] rnd;
    logic [7:0]  b8;
    cyc++;
    if (rst) begin
      awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = 0;
      arready_i = 0; rvalid_i = 0; rdata_i = 0; rresp_i = 0;
      aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
      aw_got = 0; w_got = 0; ar_got = 0; ar_prev = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      aw_hi = 0; w_hi = 0;
    end else begin
      if (tx_valid_i && tx_ready_o) tx_exp_q.push_back(tx_data_i);
      if (rx_valid_o && rx_ready_i) begin
        n_rx++;
        if (rx_exp_q.size() == 0) rx_extra++;
        else chk("rx_data", 32'(rx_data_o), 32'(rx_exp_q.pop_front()));
      end
      if (awvalid_o) aw_hi++; else if (aw_hi != 0) begin aw_run = aw_hi; aw_hi = 0; end
      if (wvalid_o)  w_hi++;  else if (w_hi != 0)  begin w_run = w_hi;   w_hi = 0;  end
      if (arvalid_o && !ar_prev) begin
        n_ar_req++;
        if (araddr_o == NUM_A) begin
          if (last_poll_cyc >= 0) poll_gap = cyc - last_poll_cyc;
          last_poll_cyc = cyc;
          n_poll_req++;
        end
      end
      ar_prev = arvalid_o;
      // retire transfers that happened on the last rising edge
      if (aw_hs) aw_got = 1;
      if (w_hs)  w_got = 1;
      if (ar_hs) ar_got = 1;
      if (b_hs) begin bvalid_i = 0; n_b++; end
      if (r_hs) rvalid_i = 0;
      // address / data readiness with programmable wait
      if (awvalid_o && !aw_got) begin awready_i = (aw_cnt >= aw_dly); aw_cnt++; end
      else begin awready_i = 0; aw_cnt = 0; if (rand_dly) aw_dly = $urandom_range(0, 3); end
      aw_hs = awvalid_o && awready_i;
      if (aw_hs) aw_a = awaddr_o;
      if (wvalid_o && !w_got) begin wready_i = (w_cnt >= w_dly); w_cnt++; end
      else begin wready_i = 0; w_cnt = 0; if (rand_dly) w_dly = $urandom_range(0, 3); end
      w_hs = wvalid_o && wready_i;
      if (w_hs) begin w_d = wdata_o; w_s = wstrb_o; end
      if (arvalid_o && !ar_got) begin arready_i = (ar_cnt >= ar_dly); ar_cnt++; end
      else begin arready_i = 0; ar_cnt = 0; if (rand_dly) ar_dly = $urandom_range(0, 3); end
      ar_hs = arvalid_o && arready_i;
      if (ar_hs) ar_a = araddr_o;
      // write response once address and data both arrived
      if (aw_got && w_got && !bvalid_i) begin
        if (b_cnt >= rsp_dly) begin
          n_writes++;
          if (tx_exp_q.size() == 0) wr_extra++;
          else begin
            b8 = tx_exp_q.pop_front();
            chk("aw_addr", 32'(aw_a), 32'(DATA_A));
            chk("wdata", w_d, {4{b8}});
            chk("wstrb", 32'(w_s), 32'hF);
          end
          bvalid_i = 1; bresp_i = bresp_next; bresp_next = 2'b00;
          aw_got = 0; w_got = 0; b_cnt = 0;
          if (rand_dly) rsp_dly = $urandom_range(0, 2);
        end else b_cnt++;
      end
      // read response: count register or FIFO pop
      if (ar_got && !rvalid_i) begin
        if (r_cnt >= rsp_dly) begin
          rnd = $urandom();
          if (ar_a == NUM_A) begin
            b8 = (uart_fifo.size() > 255) ? 8'd255 : 8'(uart_fifo.size());
            if (b8 != 0) n_polls_nz++;
            rresp_i = cnt_err_once ? 2'b10 : 2'b00;
            cnt_err_once = 0;
          end else begin
            n_data_reads++;
            if (uart_fifo.size() == 0) begin b8 = 8'hEE; fifo_under++; end
            else b8 = uart_fifo.pop_front();
            rresp_i = (dat_err_once || (dat_err_rand && $urandom_range(0, 3) == 0)) ? 2'b10 : 2'b00;
            dat_err_once = 0;
          end
          rdata_i = {rnd[31:8], b8};
          rvalid_i = 1; ar_got = 0; r_cnt = 0;
        end else r_cnt++;
      end
      b_hs = bvalid_i && bready_o;
      r_hs = rvalid_i && rready_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    @(posedge clk); #1;
    tx_valid_i = 1; tx_data_i = b;
    k = 0;
    do begin tick(); k++; end while (!tx_ready_o && k < 300);
    chk("tx_accept", 32'(tx_ready_o), 32'd1);
    @(posedge clk); #1;
    tx_valid_i = 0;
  endtask

  task automatic wait_b(input int n0);
    int k = 0;
    while (n_b <= n0 && k < 300) begin tick(); k++; end
    chk("b_wait", 32'(n_b > n0), 32'd1);
  endtask

  task automatic wait_rx_drain(input int limit);
    int k = 0;
    while ((rx_exp_q.size() != 0 || tx_exp_q.size() != 0) && k < limit) begin tick(); k++; end
    chk("drain_wait", 32'(k < limit), 32'd1);
  endtask

  task automatic wait_poll(input int p0);
    int k = 0;
    while (n_poll_req <= p0 && k < 300) begin tick(); k++; end
    chk("poll_wait", 32'(n_poll_req > p0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random stimulus ----------------
  initial begin
    int k, c, nb0, nz0, dr0, nrx0, nar0, p0;
    logic [7:0] held;
    rst = 1; tx_valid_i = 0; tx_data_i = 0; rx_ready_i = 0;
    repeat (3) @(posedge clk);
    tick();
    // reset values
    chk("rst_awvalid", 32'(awvalid_o), 0);
    chk("rst_wvalid",  32'(wvalid_o), 0);
    chk("rst_arvalid", 32'(arvalid_o), 0);
    chk("rst_readies", 32'({tx_ready_o, bready_o, rready_o, rx_valid_o}), 0);
    chk("rst_awaddr",  32'(awaddr_o), 0);
    chk("rst_araddr",  32'(araddr_o), 0);
    chk("rst_wdata",   wdata_o, 0);
    chk("rst_wstrb",   32'(wstrb_o), 0);
    chk("rst_rx_data", 32'(rx_data_o), 0);
    chk("rst_err",     32'(resp_err_o), 0);
    chk("rst_state",   32'(state_o), 0);
    chk("prot",        32'({awprot_o, arprot_o}), 0);
    @(posedge clk); #1 rst = 0;

    // TX latency: back-to-back bytes, zero-wait slave
    @(posedge clk); #1;
    tx_valid_i = 1; tx_data_i = 8'h41;
    k = 0;
    do begin tick(); k++; end while (!tx_ready_o && k < 50);
    chk("tx_first_ready", 32'(tx_ready_o), 1);
    @(posedge clk); #1 tx_data_i = 8'h42;
    c = 0;
    do begin tick(); c++; end while (!tx_ready_o && c < 50);
    chk("tx_gap", 32'(c), 3);
    @(posedge clk); #1 tx_valid_i = 0;
    wait_rx_drain(100);
    chk("tx_writes", 32'(n_writes), 2);

    // idle poll period with an empty UART
    p0 = n_poll_req;
    wait_poll(p0);
    wait_poll(p0 + 1);
    chk("poll_period", 32'(poll_gap), 32'(POLL + 2));

    // delayed awready, immediate wready
    aw_dly = 4;
    nb0 = n_b;
    send_byte(8'h55);
    wait_b(nb0);
    repeat (5) tick();
    chk("aw_hold", 32'(aw_run), 5);
    chk("w_hold", 32'(w_run), 1);
    chk("one_b", 32'(n_b - nb0), 1);
    aw_dly = 0;

    // RX: three bytes, one nonzero poll, three data reads
    rx_ready_i = 1;
    nz0 = n_polls_nz; dr0 = n_data_reads; nrx0 = n_rx;
    foreach (uart_fifo[i]) ;
    uart_fifo.push_back(8'h31); uart_fifo.push_back(8'h32); uart_fifo.push_back(8'h33);
    rx_exp_q.push_back(8'h31); rx_exp_q.push_back(8'h32); rx_exp_q.push_back(8'h33);
    wait_rx_drain(200);
    chk("rx_polls_nz", 32'(n_polls_nz - nz0), 1);
    chk("rx_data_reads", 32'(n_data_reads - dr0), 3);
    p0 = n_poll_req;
    wait_poll(p0);
    chk("rx_quiet_gap", 32'(poll_gap >= POLL), 1);
    chk("rx_quiet_beats", 32'(n_rx - nrx0), 3);

    // RX back-pressure: data held stable, no new reads
    rx_ready_i = 0;
    uart_fifo.push_back(8'hA0); uart_fifo.push_back(8'hA1);
    rx_exp_q.push_back(8'hA0); rx_exp_q.push_back(8'hA1);
    k = 0;
    while (!rx_valid_o && k < 200) begin tick(); k++; end
    chk("rx_hold_reach", 32'(rx_valid_o), 1);
    held = rx_data_o; nar0 = n_ar_req;
    chk("rx_hold_first", 32'(held), 32'hA0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("rx_hold_valid", 32'(rx_valid_o), 1);
      chk("rx_hold_data", 32'(rx_data_o), 32'(held));
      chk("rx_hold_no_ar", 32'(n_ar_req - nar0), 0);
    end
    @(posedge clk); #1 rx_ready_i = 1;
    wait_rx_drain(200);

    // write error response: sticky flag, next write still normal
    chk("err_before", 32'(resp_err_o), 0);
    bresp_next = 2'b10;
    nb0 = n_b;
    send_byte(8'h77);
    wait_b(nb0);
    tick();
    chk("err_set", 32'(resp_err_o), 1);
    nb0 = n_b;
    send_byte(8'h78);
    wait_b(nb0);
    repeat (20) tick();
    chk("err_sticky", 32'(resp_err_o), 1);
    chk("err_next_write", 32'(tx_exp_q.size()), 0);

    // errored count loads zero: no data reads until the next poll
    uart_fifo.push_back(8'hB0); uart_fifo.push_back(8'hB1);
    rx_exp_q.push_back(8'hB0); rx_exp_q.push_back(8'hB1);
    cnt_err_once = 1;
    k = 0;
    while (cnt_err_once && k < 200) begin tick(); k++; end
    chk("cnt_err_used", 32'(cnt_err_once), 0);
    dr0 = n_data_reads; p0 = n_poll_req;
    wait_poll(p0);
    chk("cnt_err_no_reads", 32'(n_data_reads - dr0), 0);
    // errored data is still delivered
    dat_err_once = 1;
    wait_rx_drain(200);

    // random traffic
    rand_dly = 1; dat_err_rand = 1;
    fork
      begin
        repeat (40) begin
          repeat ($urandom_range(0, 4)) @(posedge clk);
          send_byte(8'($urandom()));
        end
      end
      begin
        repeat (30) begin
          repeat ($urandom_range(0, 8)) @(posedge clk);
          #2;
          repeat ($urandom_range(1, 3)) begin
            held = 8'($urandom());
            uart_fifo.push_back(held);
            rx_exp_q.push_back(held);
          end
        end
      end
      begin
        repeat (400) begin
          @(posedge clk); #1 rx_ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(posedge clk); #1 rx_ready_i = 1;
    wait_rx_drain(3000);
    chk("rand_tx_left", 32'(tx_exp_q.size()), 0);
    chk("rand_rx_left", 32'(rx_exp_q.size()), 0);
    rand_dly = 0; dat_err_rand = 0; rsp_dly = 0;
    repeat (10) tick();

    // reset in the middle of a write
    aw_dly = 10; w_dly = 10;
    send_byte(8'h99);
    chk("mid_in_wr", 32'({awvalid_o, wvalid_o}), 32'b11);
    #3 rst = 1;
    #1;
    chk("mid_rst_aw", 32'(awvalid_o), 0);
    chk("mid_rst_w", 32'(wvalid_o), 0);
    chk("mid_rst_state", 32'(state_o), 0);
    chk("mid_rst_err", 32'(resp_err_o), 0);
    tx_exp_q.delete(); uart_fifo.delete(); rx_exp_q.delete();
    aw_dly = 0; w_dly = 0; ar_dly = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    nb0 = n_b; c = n_writes;
    send_byte(8'h5A);
    wait_b(nb0);
    chk("post_rst_write", 32'(n_writes - c), 1);
    chk("post_rst_left", 32'(tx_exp_q.size()), 0);

    repeat (5) tick();
    chk("rx_extra", 32'(rx_extra), 0);
    chk("wr_extra", 32'(wr_extra), 0);
    chk("fifo_under", 32'(fifo_under), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
